alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: n, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op  input  3  requester 0 ALU opcode.
REQ-007 req0_a, req0_b  input  n each  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b  same widths/meaning as REQ-004..007, requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  1  requester that issued the result.
REQ-012 rsp_data  output  n  result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states IDLE, EXEC, RESP; IDLE->EXEC on accept; EXEC->RESP always; RESP->IDLE when rsp_ready; RESP holds otherwise.
REQ-015 Accept occurs only in IDLE: reqX_ready is combinational, high only for the granted requester, only while in IDLE and its valid is high.
REQ-016 Handshake fires when reqX_valid && reqX_ready; op, a, b and id are latched into operand registers that edge.
REQ-017 Arbitration round-robin: one valid -> grant it; both valid -> grant the requester not granted last; last_grant updates only on accept.
REQ-018 At most one reqX_ready high in any cycle.
REQ-019 EXEC: shared ALU evaluates latched operands; result registered into rsp_data at end of EXEC.
REQ-020 Opcodes: 0 a; 1 ~a; 2 a&b; 3 a+b; 4 ~(a|b); 5 ~(a&b); 6 a-b; 7 unsigned (a<b) zero-extended to n.
REQ-021 Add/sub wrap modulo 2^n; no carry/overflow output.
REQ-022 Latency: accept at edge T -> rsp_valid high from edge T+2.
REQ-023 rsp_valid high exactly in RESP; rsp_data and rsp_id stable while rsp_valid && !rsp_ready.
REQ-024 No accept in the cycle rsp handshake completes; next accept earliest one cycle after leaving RESP (max throughput 1 op / 3 cycles).
REQ-025 Requester valid dropping before accept is legal; nothing latched, no grant recorded.
REQ-026 Operand changes on req ports after accept have no effect on the in-flight result.

Reset
REQ-027 rst_n low: state=IDLE, last_grant=1 (requester 0 wins first tie), operand regs=0, rsp_data=0, rsp_id=0, rsp_valid=0, busy=0, reqX_ready=0 while asserted.
REQ-028 Reset asserted in EXEC or RESP discards the in-flight operation; no response after release.

Structure
REQ-029 Shared package holds state enum (IDLE/EXEC/RESP) and opcode constants OP_PASS..OP_SLT (0..7).
REQ-030 One sub-module: the existing ALU instantiated once, parameter n passed through, fed from operand registers; arbiter contains no duplicate ALU logic.

Verification
REQ-031 Single req0 op=3 a=5 b=7 accepted at T -> rsp_valid at T+2, rsp_data=12, rsp_id=0.
REQ-032 Both valid from reset, req0 op=6 a=3 b=5, req1 op=7 a=3 b=5, rsp_ready=1 -> first rsp id=0 data=0xFFFFFFFE, second id=1 data=1; req1 accepted 3 cycles after req0.
REQ-033 Both valid continuously for 6 ops -> grants alternate 0,1,0,1,0,1; never both ready.
REQ-034 rsp_ready low 5 cycles in RESP with op=1 a=0 -> rsp_data=0xFFFFFFFF held stable, busy=1, no req accepted; completes when rsp_ready rises.
REQ-035 rst_n pulsed low during EXEC -> all outputs at REQ-027 values, no rsp_valid after release; next tie grants req0.
REQ-036 op=3 a=0xFFFFFFFF b=1 -> rsp_data=0 (wrap); op=4 a=0 b=0 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Purpose : shared types and opcode constants for the two-requester ALU arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package alu_arbiter_pkg;

  // Controller states: IDLE accepts, EXEC computes, RESP presents the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_PASS = 3'd0;  // a
  localparam logic [2:0] OP_NOT  = 3'd1;  // ~a
  localparam logic [2:0] OP_AND  = 3'd2;  // a & b
  localparam logic [2:0] OP_ADD  = 3'd3;  // a + b (wraps)
  localparam logic [2:0] OP_NOR  = 3'd4;  // ~(a | b)
  localparam logic [2:0] OP_NAND = 3'd5;  // ~(a & b)
  localparam logic [2:0] OP_SUB  = 3'd6;  // a - b (wraps)
  localparam logic [2:0] OP_SLT  = 3'd7;  // unsigned a < b, zero-extended

endpackage

// File: rtl/alu_arbiter_if.sv
// Purpose : bundles both requester ports, the response port and busy.
// Latency : n/a (wiring only).
// Backpressure: reqX_ready / rsp_ready handshakes carried through unchanged.
// Ports   : req0_*/req1_* (valid, ready, op, a, b), rsp_* (valid, ready, id, data), busy.
interface alu_arbiter_if #(
  parameter int n = 32
);
  logic         req0_valid;
  logic         req0_ready;
  logic [2:0]   req0_op;
  logic [n-1:0] req0_a;
  logic [n-1:0] req0_b;

  logic         req1_valid;
  logic         req1_ready;
  logic [2:0]   req1_op;
  logic [n-1:0] req1_a;
  logic [n-1:0] req1_b;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [n-1:0] rsp_data;

  logic         busy;

  // Requester/consumer side.
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, busy
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Purpose : purely combinational n-bit ALU with eight operations.
// Latency : 0 cycles (combinational).
// Backpressure: none; output follows inputs.
// Ports   : i_op opcode, i_a/i_b operands, o_y result.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [2:0]   i_op,
  input  logic [n-1:0] i_a,
  input  logic [n-1:0] i_b,
  output logic [n-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_PASS: o_y = i_a;
      OP_NOT:  o_y = ~i_a;
      OP_AND:  o_y = i_a & i_b;
      OP_ADD:  o_y = i_a + i_b;
      OP_NOR:  o_y = ~(i_a | i_b);
      OP_NAND: o_y = ~(i_a & i_b);
      OP_SUB:  o_y = i_a - i_b;
      OP_SLT:  o_y[0] = (i_a < i_b);
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Purpose : round-robin arbiter sharing one ALU between two requesters.
// Latency : handshake cycle T -> rsp_valid from edge T+2; 1 op per 3 cycles max.
// Backpressure: reqX_ready only in IDLE; RESP holds result until rsp_ready.
// Ports   : clk, rst_n (async, active-low), bus (alu_arbiter_if.slave).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_last_grant;   // requester granted most recently
  logic [2:0]   r_op;
  logic [n-1:0] r_a;
  logic [n-1:0] r_b;
  logic         r_id;
  logic [n-1:0] r_rsp_data;
  logic         r_rsp_id;
  logic         w_grant0;
  logic         w_grant1;
  logic         w_accept;
  logic [n-1:0] w_alu_y;

  // Next-state and grant logic. Grants are also gated by rst_n so no ready
  // escapes while reset is held (state already reads IDLE then).
  always_comb begin
    w_state_nxt = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n) begin
          // On a tie the requester not granted last wins.
          w_grant0 = bus.req0_valid && (!bus.req1_valid || r_last_grant);
          w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
        end
        if (w_grant0 || w_grant1) begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = w_grant0 || w_grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture on accept; result capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_id     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op         <= w_grant1 ? bus.req1_op : bus.req0_op;
        r_a          <= w_grant1 ? bus.req1_a  : bus.req0_a;
        r_b          <= w_grant1 ? bus.req1_b  : bus.req0_b;
        r_id         <= w_grant1;
        r_last_grant <= w_grant1;
      end
      if (r_state == EXEC) begin
        r_rsp_data <= w_alu_y;
        r_rsp_id   <= r_id;
      end
    end
  end

  alu_arbiter_alu #(
    .n (n)
  ) u_alu (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_alu_y)
  );

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;
  assign bus.rsp_valid  = (r_state == RESP);
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose : directed self-checking bench for alu_arbiter (vector table + sequences).
// Latency : n/a.
// Backpressure: exercises held responses and requester drop-out.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;

  alu_arbiter_if #(.n(32)) bus ();

  alu_arbiter #(.n(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [13];
  int          n_chk;
  int          n_fail;
  int          na;
  int          nr;
  int          both_cnt;
  logic        g_id  [8];
  int          g_cyc [8];
  logic        s_id  [8];
  logic [31:0] s_dat [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_reqs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  // Single-requester transaction with latency, data and id checks.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    bit got;
    @(negedge clk);
    if (v.id == 1'b0) begin
      bus.req0_valid = 1'b1; bus.req0_op = v.op; bus.req0_a = v.a; bus.req0_b = v.b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = v.op; bus.req1_a = v.a; bus.req1_b = v.b;
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk($sformatf("vec%0d_ready", idx), {31'd0, (v.id ? bus.req1_ready : bus.req0_ready)}, 32'd1);
    @(posedge clk); #1;
    // Scramble the request ports after accept; the result must not change.
    clear_reqs();
    bus.req0_a = ~v.a; bus.req0_b = v.b + 32'd1; bus.req0_op = v.op ^ 3'd5;
    bus.req1_a = ~v.a; bus.req1_b = v.b + 32'd1; bus.req1_op = v.op ^ 3'd5;
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 8) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    chk($sformatf("vec%0d_latency", idx), got ? cyc : 99, 32'd2);
    chk($sformatf("vec%0d_data", idx), bus.rsp_data, v.exp);
    chk($sformatf("vec%0d_id", idx), {31'd0, bus.rsp_id}, {31'd0, v.id});
    chk($sformatf("vec%0d_busy", idx), {31'd0, bus.busy}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Runs with whatever valids are set, logging grants and responses.
  task automatic run_pair(input int want, input bit one_shot);
    int cyc;
    int g;
    na = 0; nr = 0; both_cnt = 0; cyc = 0;
    while ((na < want || nr < want) && cyc < 200) begin
      @(negedge clk);
      g = -1;
      if (bus.req0_ready && bus.req1_ready) both_cnt++;
      if (bus.req0_ready) g = 0;
      else if (bus.req1_ready) g = 1;
      if (g >= 0 && na < 8) begin
        g_id[na] = g[0]; g_cyc[na] = cyc; na++;
      end
      if (bus.rsp_valid && bus.rsp_ready && nr < 8) begin
        s_id[nr] = bus.rsp_id; s_dat[nr] = bus.rsp_data; nr++;
      end
      @(posedge clk); #1;
      if (na >= want) clear_reqs();
      else if (one_shot && g == 0) bus.req0_valid = 1'b0;
      else if (one_shot && g == 1) bus.req1_valid = 1'b0;
      cyc++;
    end
    chk("pair_accepts", na, want);
    chk("pair_rsps", nr, want);
    chk("never_both_ready", both_cnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    vecs[0]  = '{1'b0, 3'd3, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C};
    vecs[1]  = '{1'b1, 3'd0, 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 3'd1, 32'h0F0F_0000, 32'h0000_0000, 32'hF0F0_FFFF};
    vecs[3]  = '{1'b1, 3'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00};
    vecs[4]  = '{1'b0, 3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[5]  = '{1'b1, 3'd4, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[6]  = '{1'b0, 3'd4, 32'hF0F0_F0F0, 32'h0000_FFFF, 32'h0F0F_0000};
    vecs[7]  = '{1'b1, 3'd5, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FFFF};
    vecs[8]  = '{1'b0, 3'd6, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007};
    vecs[9]  = '{1'b1, 3'd6, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[10] = '{1'b0, 3'd7, 32'h0000_0003, 32'h0000_0005, 32'h0000_0001};
    vecs[11] = '{1'b1, 3'd7, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[12] = '{1'b0, 3'd7, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000};

    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready = 1'b1;

    // Reset state, with both requesters asserting valid.
    #1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    clear_reqs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tie from reset: req0 first, req1 three cycles later.
    bus.req0_valid = 1'b1; bus.req0_op = 3'd6; bus.req0_a = 32'd3; bus.req0_b = 32'd5;
    bus.req1_valid = 1'b1; bus.req1_op = 3'd7; bus.req1_a = 32'd3; bus.req1_b = 32'd5;
    run_pair(2, 1'b1);
    chk("tie_first_grant", {31'd0, g_id[0]}, 32'd0);
    chk("tie_second_grant", {31'd0, g_id[1]}, 32'd1);
    chk("tie_accept_gap", g_cyc[1] - g_cyc[0], 32'd3);
    chk("tie_rsp0_id", {31'd0, s_id[0]}, 32'd0);
    chk("tie_rsp0_data", s_dat[0], 32'hFFFF_FFFE);
    chk("tie_rsp1_id", {31'd0, s_id[1]}, 32'd1);
    chk("tie_rsp1_data", s_dat[1], 32'h0000_0001);

    // Both valid for six operations: strict alternation.
    bus.req0_valid = 1'b1; bus.req0_op = 3'd3; bus.req0_a = 32'd10;   bus.req0_b = 32'd20;
    bus.req1_valid = 1'b1; bus.req1_op = 3'd2; bus.req1_a = 32'hF0;   bus.req1_b = 32'h3C;
    run_pair(6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_grant%0d", i), {31'd0, g_id[i]}, i % 2);
      chk($sformatf("rr_rsp_id%0d", i), {31'd0, s_id[i]}, i % 2);
      chk($sformatf("rr_rsp_data%0d", i), s_dat[i], (i % 2 == 1) ? 32'h30 : 32'h1E);
    end

    // Table of single operations.
    for (int i = 0; i < 13; i++) begin
      run_vec(i, vecs[i]);
    end

    // Held response: rsp_ready low for five RESP cycles.
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 3'd1; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
    @(negedge clk);
    chk("hold_accept", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = 3'd0; bus.req1_a = 32'h55; bus.req1_b = 32'd0;
    @(negedge clk);
    chk("hold_exec_ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", i), {31'd0, bus.rsp_valid}, 32'd1);
      chk($sformatf("hold%0d_data", i), bus.rsp_data, 32'hFFFF_FFFF);
      chk($sformatf("hold%0d_id", i), {31'd0, bus.rsp_id}, 32'd0);
      chk($sformatf("hold%0d_busy", i), {31'd0, bus.busy}, 32'd1);
      chk($sformatf("hold%0d_ready1", i), {31'd0, bus.req1_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_done_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("hold_done_ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_resp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("after_resp_busy", {31'd0, bus.busy}, 32'd0);
    chk("after_resp_ready1", {31'd0, bus.req1_ready}, 32'd1);
    // req1 withdraws before the edge: nothing accepted, no grant recorded.
    bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("withdraw_busy", {31'd0, bus.busy}, 32'd0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("withdraw_tie_ready1", {31'd0, bus.req1_ready}, 32'd1);
    chk("withdraw_tie_ready0", {31'd0, bus.req0_ready}, 32'd0);
    clear_reqs();
    @(posedge clk); #1;

    // Reset during EXEC discards the operation and restores the tie order.
    bus.req0_valid = 1'b1; bus.req0_op = 3'd3; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
    @(negedge clk);
    chk("rst2_accept", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    chk("rst2_ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("rst2_ready1", {31'd0, bus.req1_ready}, 32'd0);
    chk("rst2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst2_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst2_rsp_data", bus.rsp_data, 32'd0);
    chk("rst2_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    clear_reqs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst2_quiet%0d_valid", i), {31'd0, bus.rsp_valid}, 32'd0);
      chk($sformatf("rst2_quiet%0d_busy", i), {31'd0, bus.busy}, 32'd0);
    end
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("rst2_tie_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("rst2_tie_ready1", {31'd0, bus.req1_ready}, 32'd0);
    clear_reqs();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
